// File: rtl/frog_game_ctrl_if.sv
// Bus between the game controller and its surroundings.
//
// Signals:
//   i_animate  end-of-frame strobe, one cycle wide
//   i_hit      frog/obstacle overlap, only meaningful while i_animate=1
//   i_frog_y1  frog top edge in pixels, only meaningful while i_animate=1
//   i_start    start request level, already synchronised
//   o_freeze   animators hold position while high
//   o_frog_rst one-cycle pulse returning the frog to its start position
//   o_flash    frog blank/visible toggle while dying
//   o_lives    remaining lives
//   o_score    levels cleared, saturating
//   o_game_over high while the game is over
//   o_state    current controller state (debug/observability)
//
// Handshake: there is no valid/ready pair. i_animate is the only qualifier;
// i_hit and i_frog_y1 are sampled on cycles with i_animate=1 and ignored
// otherwise. All o_* signals are registered and always valid after reset.
//
// Modports: master drives the inputs (top level / bench), slave is the
// controller itself.
interface frog_game_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               i_animate;
  logic               i_hit;
  logic [11:0]        i_frog_y1;
  logic               i_start;
  logic               o_freeze;
  logic               o_frog_rst;
  logic               o_flash;
  logic [1:0]         o_lives;
  logic [SCORE_W-1:0] o_score;
  logic               o_game_over;
  logic [2:0]         o_state;

  modport master (
    output i_animate, i_hit, i_frog_y1, i_start,
    input  o_freeze, o_frog_rst, o_flash, o_lives, o_score, o_game_over, o_state
  );

  modport slave (
    input  i_animate, i_hit, i_frog_y1, i_start,
    output o_freeze, o_frog_rst, o_flash, o_lives, o_score, o_game_over, o_state
  );
endinterface

// File: rtl/frog_game_ctrl.sv
// Game-sequencing controller for the VGA frog game.
//
// Sequences IDLE -> RESPAWN -> PLAY, and from PLAY into DYING (on a hit)
// or WIN (frog reached the goal row), back through RESPAWN, ending in
// GAMEOVER when the last life is lost. Drives the animator freeze,
// frog-reset and flash controls and keeps lives and score.
//
// Ports:
//   i_clk  system clock
//   i_rst  synchronous active-high reset
//   bus    frog_game_ctrl_if.slave (strobe/hit/y/start in, controls out)
module frog_game_ctrl #(
  parameter int LIVES        = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int WIN_FRAMES   = 30,
  parameter int FLASH_FRAMES = 8,
  parameter int GOAL_Y       = 40,
  parameter int SCORE_W      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  frog_game_ctrl_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAY     = 3'd1,
    DYING    = 3'd2,
    RESPAWN  = 3'd3,
    WIN      = 3'd4,
    GAMEOVER = 3'd5
  } state_t;

  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
  localparam logic [7:0]  DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0]  WIN_LAST   = 8'(WIN_FRAMES - 1);
  localparam logic [7:0]  FLASH_LAST = 8'(FLASH_FRAMES - 1);
  localparam logic [11:0] GOAL       = 12'(GOAL_Y);

  state_t               state, state_n;
  logic [7:0]           cnt, cnt_n;
  // Phase within the current flash half-period; avoids a modulo on cnt.
  logic [7:0]           fph, fph_n;
  logic                 flash, flash_n;
  logic [1:0]           lives, lives_n;
  logic [SCORE_W-1:0]   score, score_n;
  logic                 freeze, freeze_n;
  logic                 frog_rst, frog_rst_n;
  logic                 game_over, game_over_n;
  logic                 start_q;
  logic                 start_edge;

  // start_q resets to 1 so a start held through reset does not fire.
  assign start_edge = bus.i_start & ~start_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      fph       <= 8'd0;
      flash     <= 1'b0;
      lives     <= LIVES_INIT;
      score     <= '0;
      freeze    <= 1'b1;
      frog_rst  <= 1'b0;
      game_over <= 1'b0;
      start_q   <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      fph       <= fph_n;
      flash     <= flash_n;
      lives     <= lives_n;
      score     <= score_n;
      freeze    <= freeze_n;
      frog_rst  <= frog_rst_n;
      game_over <= game_over_n;
      start_q   <= bus.i_start;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fph_n   = fph;
    flash_n = flash;
    lives_n = lives;
    score_n = score;

    case (state)
      IDLE, GAMEOVER: begin
        if (start_edge) begin
          lives_n = LIVES_INIT;
          score_n = '0;
          state_n = RESPAWN;
        end
      end
      RESPAWN: state_n = PLAY;
      PLAY: begin
        if (bus.i_animate) begin
          if (bus.i_hit) begin
            state_n = DYING;
            flash_n = 1'b1;
          end else if (bus.i_frog_y1 <= GOAL) begin
            state_n = WIN;
            if (score != '1) score_n = score + 1'b1;
          end
        end
      end
      DYING: begin
        if (bus.i_animate) begin
          if (cnt == DEATH_LAST) begin
            flash_n = 1'b0;
            if (lives != 2'd0) lives_n = lives - 2'd1;
            state_n = (lives <= 2'd1) ? GAMEOVER : RESPAWN;
          end else begin
            cnt_n = cnt + 8'd1;
            if (fph == FLASH_LAST) begin
              fph_n   = 8'd0;
              flash_n = ~flash;
            end else begin
              fph_n = fph + 8'd1;
            end
          end
        end
      end
      WIN: begin
        if (bus.i_animate) begin
          if (cnt == WIN_LAST) state_n = RESPAWN;
          else                 cnt_n   = cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        flash_n = 1'b0;
      end
    endcase

    // Counters start from zero in every newly entered state.
    if (state_n != state) begin
      cnt_n = 8'd0;
      fph_n = 8'd0;
    end

    freeze_n    = (state_n != PLAY);
    frog_rst_n  = (state_n == RESPAWN);
    game_over_n = (state_n == GAMEOVER);
  end

  assign bus.o_state     = state;
  assign bus.o_freeze    = freeze;
  assign bus.o_frog_rst  = frog_rst;
  assign bus.o_flash     = flash;
  assign bus.o_lives     = lives;
  assign bus.o_score     = score;
  assign bus.o_game_over = game_over;

endmodule

// File: tb/tb_frog_game_ctrl.sv
module tb_frog_game_ctrl;
  localparam int SW     = 2;
  localparam int NLIVES = 3;
  localparam int DEATHF = 60;
  localparam int WINF   = 30;
  localparam int FLASHF = 8;
  localparam int GOALY  = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frog_game_ctrl_if #(.SCORE_W(SW)) bus();

  frog_game_ctrl #(
    .LIVES(NLIVES), .DEATH_FRAMES(DEATHF), .WIN_FRAMES(WINF),
    .FLASH_FRAMES(FLASHF), .GOAL_Y(GOALY), .SCORE_W(SW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  // Phase numbers follow the o_state encoding; frames are counted as the
  // number of strobes seen in the current phase.
  int m_state  = 0;
  int m_lives  = NLIVES;
  int m_score  = 0;
  int m_dying  = 0;
  int m_win    = 0;
  bit m_sprev  = 1'b1;
  logic [10:0] exp_q[$];

  function automatic logic [10:0] model_outputs();
    logic       fl;
    fl = (m_state == 2) && (((m_dying / FLASHF) % 2) == 0);
    return {3'(m_state), 1'(m_state != 1), 1'(m_state == 3), fl,
            2'(m_lives), 2'(m_score), 1'(m_state == 5)};
  endfunction

  always @(posedge clk) begin
    bit edge_seen;
    edge_seen = bus.i_start && !m_sprev;
    m_sprev   = bus.i_start;
    if (rst) begin
      m_state = 0; m_lives = NLIVES; m_score = 0;
      m_dying = 0; m_win = 0; m_sprev = 1'b1;
    end else begin
      case (m_state)
        0, 5: if (edge_seen) begin
          m_lives = NLIVES; m_score = 0; m_state = 3;
        end
        3: m_state = 1;
        1: if (bus.i_animate) begin
          if (bus.i_hit) begin
            m_state = 2; m_dying = 0;
          end else if (int'(bus.i_frog_y1) <= GOALY) begin
            m_state = 4; m_win = 0;
            m_score = (m_score + 1 > (1 << SW) - 1) ? (1 << SW) - 1 : m_score + 1;
          end
        end
        2: if (bus.i_animate) begin
          m_dying++;
          if (m_dying == DEATHF) begin
            if (m_lives > 0) m_lives--;
            m_state = (m_lives == 0) ? 5 : 3;
          end
        end
        4: if (bus.i_animate) begin
          m_win++;
          if (m_win == WINF) m_state = 3;
        end
        default: m_state = 0;
      endcase
    end
    exp_q.push_back(model_outputs());
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [10:0] act, e;
    act = {bus.o_state, bus.o_freeze, bus.o_frog_rst, bus.o_flash,
           bus.o_lives, bus.o_score, bus.o_game_over};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL model_cmp t=%0t no expectation queued actual=%b", $time, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL model_cmp t=%0t actual=%b expected=%b (state,frz,frst,flash,lives,score,go)",
                 $time, act, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic hit, input logic [11:0] y);
    bus.i_animate = 1'b1;
    bus.i_hit     = hit;
    bus.i_frog_y1 = y;
    step(1);
    bus.i_animate = 1'b0;
    bus.i_hit     = 1'b0;
    bus.i_frog_y1 = 12'd200;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Hit on one strobe then DEATHF strobes in DYING.
  task automatic die();
    step(2);
    strobe(1'b1, 12'd200);
    repeat (DEATHF) begin
      step(2);
      strobe(1'b0, 12'd200);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.i_animate = 1'b0;
    bus.i_hit     = 1'b0;
    bus.i_frog_y1 = 12'd200;
    bus.i_start   = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    check("held_start_state", bus.o_state, 0);
    check("reset_freeze", bus.o_freeze, 1);
    check("reset_lives", bus.o_lives, 3);
    check("reset_score", bus.o_score, 0);
    check("reset_flash", bus.o_flash, 0);
    check("reset_frog_rst", bus.o_frog_rst, 0);
    check("reset_game_over", bus.o_game_over, 0);

    bus.i_start = 1'b0;
    step(2);
    bus.i_start = 1'b1;
    step(1);
    check("start_respawn_state", bus.o_state, 3);
    check("start_frog_rst", bus.o_frog_rst, 1);
    step(1);
    check("start_play_state", bus.o_state, 1);
    check("start_play_freeze", bus.o_freeze, 0);
    check("start_frog_rst_done", bus.o_frog_rst, 0);
    bus.i_start = 1'b0;

    // Goal at exactly GOAL_Y.
    step(2);
    strobe(1'b0, 12'd40);
    check("win_state", bus.o_state, 4);
    check("win_score", bus.o_score, 1);
    for (int k = 1; k <= WINF; k++) begin
      step(2);
      strobe(1'b0, 12'd200);
      if (k == WINF - 1) check("win_hold", bus.o_state, 4);
    end
    check("win_respawn", bus.o_state, 3);
    check("win_lives", bus.o_lives, 3);
    step(1);
    check("win_play", bus.o_state, 1);

    // One pixel below the goal row.
    step(2);
    strobe(1'b0, 12'd41);
    check("y41_no_win", bus.o_state, 1);

    // Hit beats goal on the same strobe.
    step(2);
    strobe(1'b1, 12'd10);
    check("hit_prio_state", bus.o_state, 2);
    check("hit_prio_score", bus.o_score, 1);
    check("dying_flash_entry", bus.o_flash, 1);
    for (int k = 1; k <= DEATHF; k++) begin
      step(2);
      strobe(1'b0, 12'd200);
      if (k == 7)  check("flash_after7", bus.o_flash, 1);
      if (k == 8)  check("flash_after8", bus.o_flash, 0);
      if (k == 16) check("flash_after16", bus.o_flash, 1);
      if (k == 56) check("flash_after56", bus.o_flash, 0);
      if (k == DEATHF - 1) check("dying_hold", bus.o_state, 2);
    end
    check("death_respawn", bus.o_state, 3);
    check("death_lives", bus.o_lives, 2);
    check("death_frog_rst", bus.o_frog_rst, 1);
    check("death_flash_off", bus.o_flash, 0);
    step(1);
    check("death_play", bus.o_state, 1);

    // Hit and goal between strobes are ignored.
    bus.i_hit = 1'b1;
    bus.i_frog_y1 = 12'd5;
    step(4);
    bus.i_hit = 1'b0;
    bus.i_frog_y1 = 12'd200;
    check("hit_between_strobes", bus.o_state, 1);

    die();
    check("second_death_lives", bus.o_lives, 1);
    step(1);
    die();
    check("gameover_state", bus.o_state, 5);
    check("gameover_flag", bus.o_game_over, 1);
    check("gameover_lives", bus.o_lives, 0);
    check("gameover_score_held", bus.o_score, 1);
    step(3);
    check("gameover_stays", bus.o_state, 5);

    bus.i_start = 1'b1;
    step(1);
    check("restart_respawn", bus.o_state, 3);
    check("restart_lives", bus.o_lives, 3);
    check("restart_score", bus.o_score, 0);
    bus.i_start = 1'b0;
    step(1);
    check("restart_play", bus.o_state, 1);

    // Score saturation at 2^SW-1 = 3.
    for (int lv = 1; lv <= 5; lv++) begin
      step(2);
      strobe(1'b0, 12'd40);
      check("sat_score", bus.o_score, (lv < 3) ? lv : 3);
      repeat (WINF) begin
        step(2);
        strobe(1'b0, 12'd200);
      end
      step(1);
    end

    // Reset in the middle of DYING.
    step(2);
    strobe(1'b1, 12'd200);
    repeat (20) begin
      step(2);
      strobe(1'b0, 12'd200);
    end
    check("mid_dying_flash", bus.o_flash, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_dying_state", bus.o_state, 0);
    check("rst_dying_freeze", bus.o_freeze, 1);
    check("rst_dying_flash", bus.o_flash, 0);
    check("rst_dying_lives", bus.o_lives, 3);
    check("rst_dying_score", bus.o_score, 0);

    // Reset aborts the respawn pulse.
    step(2);
    bus.i_start = 1'b1;
    step(1);
    check("pre_abort_frog_rst", bus.o_frog_rst, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("abort_frog_rst", bus.o_frog_rst, 0);
    check("abort_state", bus.o_state, 0);
    step(3);
    check("abort_held_start", bus.o_state, 0);
    bus.i_start = 1'b0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
